// File: rtl/hls_run_sequencer_if.sv
// Command, core-control and result signals of the run sequencer.
// master = the sequencer itself, slave = the host/core environment around it.
interface hls_run_sequencer_if #(
  parameter int CYCLE_W = 32,
  parameter int RUN_W   = 8
);
  logic               cmd_start;
  logic [RUN_W-1:0]   cmd_num_runs;
  logic               cmd_abort;
  logic               kernel_reset;
  logic               start_port;
  logic               done_port;
  logic               check_en;
  logic               check_ok;
  logic               busy;
  logic               result_valid;
  logic [1:0]         result_status;
  logic [CYCLE_W-1:0] result_cycles;
  logic [RUN_W-1:0]   result_run_idx;
  logic [RUN_W-1:0]   pass_count;
  logic [RUN_W-1:0]   fail_count;
  logic               batch_done;
  logic               aborted;

  modport master (
    input  cmd_start, cmd_num_runs, cmd_abort, done_port, check_en, check_ok,
    output kernel_reset, start_port, busy, result_valid, result_status, result_cycles,
           result_run_idx, pass_count, fail_count, batch_done, aborted
  );

  modport slave (
    output cmd_start, cmd_num_runs, cmd_abort, done_port, check_en, check_ok,
    input  kernel_reset, start_port, busy, result_valid, result_status, result_cycles,
           result_run_idx, pass_count, fail_count, batch_done, aborted
  );
endinterface

// File: rtl/hls_run_sequencer.sv
// Batch run controller for one HLS core: reset, start, time, grade and count each run.
// Result strobe one cycle after done/timeout; no backpressure, all strobes are one cycle wide.
module hls_run_sequencer #(
  parameter int CYCLE_W        = 32,
  parameter int RUN_W          = 8,
  parameter int TIMEOUT_CYCLES = 200000000,
  parameter int RESET_CYCLES   = 2
) (
  input logic                 clock,
  input logic                 reset,
  hls_run_sequencer_if.master bus
);
  localparam int KW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [1:0] ST_PASS     = 2'b00;
  localparam logic [1:0] ST_FAIL     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT  = 2'b10;
  localparam logic [1:0] ST_UNGRADED = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_KRST, S_START, S_WAIT, S_REPORT, S_FIN} state_t;

  state_t             state;
  logic [RUN_W-1:0]   runs;
  logic [RUN_W-1:0]   run_idx;
  logic [KW-1:0]      krst_cnt;
  logic [CYCLE_W-1:0] lat;
  logic               run_active;
  logic               hit_timeout;
  logic               run_end;
  logic [1:0]         run_status;

  // lat always holds the latency of the current cycle, so START and WAIT share one end test
  assign run_active  = (state == S_START) || (state == S_WAIT);
  assign hit_timeout = (state == S_WAIT) && !bus.done_port && (lat == CYCLE_W'(TIMEOUT_CYCLES));
  assign run_end     = run_active && (bus.done_port || hit_timeout);
  assign run_status  = hit_timeout   ? ST_TIMEOUT  :
                       !bus.check_en ? ST_UNGRADED :
                       bus.check_ok  ? ST_PASS     : ST_FAIL;

  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= S_IDLE;
      runs                <= '0;
      run_idx             <= '0;
      krst_cnt            <= '0;
      lat                 <= '0;
      bus.kernel_reset    <= 1'b1;
      bus.start_port      <= 1'b0;
      bus.busy            <= 1'b0;
      bus.result_valid    <= 1'b0;
      bus.result_status   <= 2'b00;
      bus.result_cycles   <= '0;
      bus.result_run_idx  <= '0;
      bus.pass_count      <= '0;
      bus.fail_count      <= '0;
      bus.batch_done      <= 1'b0;
      bus.aborted         <= 1'b0;
    end else begin
      bus.start_port   <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.batch_done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cmd_start) begin
            runs           <= (bus.cmd_num_runs == '0) ? RUN_W'(1) : bus.cmd_num_runs;
            run_idx        <= '0;
            bus.pass_count <= '0;
            bus.fail_count <= '0;
            bus.aborted    <= 1'b0;
            bus.busy       <= 1'b1;
            krst_cnt       <= '0;
            state          <= S_KRST;
          end
        end
        S_KRST: begin
          if (bus.cmd_abort) begin
            bus.aborted    <= 1'b1;
            bus.batch_done <= 1'b1;
            state          <= S_FIN;
          end else if (krst_cnt == KW'(RESET_CYCLES - 1)) begin
            bus.kernel_reset <= 1'b0;
            bus.start_port   <= 1'b1;
            lat              <= CYCLE_W'(1);
            state            <= S_START;
          end else begin
            krst_cnt <= krst_cnt + KW'(1);
          end
        end
        S_START, S_WAIT: begin
          if (run_end) begin
            // a done in the abort cycle still completes and reports the run
            bus.result_valid   <= 1'b1;
            bus.result_status  <= run_status;
            bus.result_cycles  <= lat;
            bus.result_run_idx <= run_idx;
            if (run_status == ST_PASS)
              bus.pass_count <= bus.pass_count + RUN_W'(1);
            else if (run_status != ST_UNGRADED)
              bus.fail_count <= bus.fail_count + RUN_W'(1);
            if (hit_timeout || bus.cmd_abort)
              bus.aborted <= 1'b1;
            state <= S_REPORT;
          end else if (bus.cmd_abort && (state == S_START)) begin
            bus.aborted      <= 1'b1;
            bus.batch_done   <= 1'b1;
            bus.kernel_reset <= 1'b1;
            state            <= S_FIN;
          end else begin
            if (bus.cmd_abort)
              bus.aborted <= 1'b1;
            lat   <= lat + CYCLE_W'(1);
            state <= S_WAIT;
          end
        end
        S_REPORT: begin
          bus.kernel_reset <= 1'b1;
          if (bus.aborted || bus.cmd_abort || (run_idx == runs - RUN_W'(1))) begin
            if (bus.cmd_abort)
              bus.aborted <= 1'b1;
            bus.batch_done <= 1'b1;
            state          <= S_FIN;
          end else begin
            run_idx  <= run_idx + RUN_W'(1);
            krst_cnt <= '0;
            state    <= S_KRST;
          end
        end
        S_FIN: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/hls_run_sequencer.md
Name: hls_run_sequencer

Overview:
Synthesizable run controller for one Bambu-generated accelerator core. It resets the core, pulses start_port, waits for done_port and measures latency in clock cycles. It also grades each run against an external checker flag and enforces a timeout. It repeats this for a programmable number of back-to-back runs, so batch latency and pass/fail statistics can be collected on-chip instead of in a testbench.

Parameters:
CYCLE_W, 32, width of the latency counter and of result_cycles
RUN_W, 8, width of run count, run index and pass/fail counters
TIMEOUT_CYCLES, 200000000, latency at which a run is declared hung; must be < 2**CYCLE_W
RESET_CYCLES, 2, number of cycles kernel_reset is held before each start

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
cmd_start  in  1  one-cycle request to begin a batch; ignored while busy
cmd_num_runs  in  RUN_W  runs in the batch, sampled on accepted cmd_start; 0 is treated as 1
cmd_abort  in  1  abandon the batch at the next state boundary
kernel_reset  out  1  active-high reset to the accelerator core
start_port  out  1  one-cycle start pulse to the core
done_port  in  1  core completion, sampled every cycle
check_en  in  1  1 = grade with check_ok; 0 = ungraded
check_ok  in  1  checker verdict, sampled in the cycle done_port is 1
busy  out  1  high from accepted cmd_start until batch_done
result_valid  out  1  one-cycle strobe per finished run
result_status  out  2  00 pass, 01 fail, 10 timeout, 11 ungraded
result_cycles  out  CYCLE_W  latency of the reported run
result_run_idx  out  RUN_W  0-based index of the reported run
pass_count  out  RUN_W  passes in the current/last batch
fail_count  out  RUN_W  fails plus timeouts in the current/last batch
batch_done  out  1  one-cycle strobe at batch end
aborted  out  1  sticky until next accepted cmd_start: batch ended by timeout or cmd_abort

Behaviour:
- Reset values:
  - kernel_reset=1; all other outputs 0; counters 0; state IDLE.
  - Reset mid-batch discards everything, with no result_valid and no batch_done.
- States:
  - IDLE: kernel_reset=1, busy=0.
    - On cmd_start: latch runs = max(cmd_num_runs,1), clear run_idx, pass_count, fail_count and aborted, then go to KRST.
  - KRST: kernel_reset=1 for exactly RESET_CYCLES cycles, then START.
  - START: kernel_reset=0, start_port=1 for exactly this one cycle, and lat=1.
    - If done_port=1 in this cycle, go to REPORT.
    - Otherwise go to WAIT.
  - WAIT: each cycle, lat=lat+1.
    - On done_port=1: the cycles value is lat including the done cycle, and check_ok is captured.
    - If lat reaches TIMEOUT_CYCLES without done: result_cycles=TIMEOUT_CYCLES, status=10, aborted=1.
    - Either way, go to REPORT.
  - REPORT: result_valid=1 for one cycle, and the outputs are updated.
    - Status: pass/fail from check_ok when check_en=1, 11 when check_en=0.
    - Counters: status 00 increments pass_count; 01 or 10 increments fail_count; 11 changes neither.
    - Next state is FIN if timeout occurred, aborted is set, or run_idx+1==runs.
    - Otherwise run_idx increments and the next state is KRST.
  - FIN: batch_done=1 for one cycle, kernel_reset=1, then IDLE.
- Latency definition:
  - The start cycle counts as 1.
  - If done is seen in the cycle right after start, result_cycles=2.
  - If done is in the same cycle as start, result_cycles=1.
- cmd_abort:
  - In KRST or START: sets aborted and goes to FIN with no result for the pending run.
  - In WAIT: the current run finishes or times out and is reported, then FIN.
  - cmd_abort and done_port in the same cycle: done wins for that run, then FIN.
- Output hold:
  - result_* keep their value until the next REPORT.
  - pass_count and fail_count keep their value until the next accepted cmd_start.
- done_port is ignored outside START and WAIT.
- cmd_start while busy is dropped.
- No counter wraps: lat stops at TIMEOUT_CYCLES, and run counters cannot exceed runs ≤ 2**RUN_W-1.

Test Plan:
- cmd_num_runs=1, check_en=1; core raises done 10 cycles after start_port with check_ok=1 -> start_port high 1 cycle after 2 reset cycles; result_cycles=11, status 00, pass_count=1, batch_done one cycle after result_valid.
- cmd_num_runs=3, done after 4 cycles each; check_ok pattern 1,0,1 -> three result_valid strobes with idx 0,1,2 and cycles=5; pass_count=2, fail_count=1; kernel_reset reasserted for 2 cycles between runs.
- TIMEOUT_CYCLES=50 (overridden), done never rises, cmd_num_runs=4 -> one result: status 10, cycles=50; aborted=1; batch_done; no further start_port.
- cmd_num_runs=0, check_en=0, done in the same cycle as start_port -> one run, status 11, cycles=1, both counters 0.
- Apply reset while in WAIT of run 1 of 2 -> no result_valid or batch_done; all outputs at reset values the next cycle; kernel_reset=1.
- cmd_abort asserted in WAIT together with done_port and check_ok=1 -> run reported as pass; then batch_done; aborted=1; a second cmd_start pulse during busy is ignored.
